// File: rtl/aqed_pkg.sv
// -----------------------------------------------------------------------------
// aqed_pkg
//   Shared types and constants for the A-QED multi-duplicate checker.
//   - state_e  : checker FSM states
//   - cnt_t    : widest supported sequence counter / captured index
//   - IDX_NONE : "no index latched" sentinel; all-ones never matches a live
//                counter because the counters saturate one below it
//   - timer_t  : timeout counter
// -----------------------------------------------------------------------------
package aqed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUING,
        WAIT_OUT,
        DONE
    } state_e;

    localparam int unsigned CNT_W_MAX = 32;

    typedef logic [CNT_W_MAX-1:0] cnt_t;

    localparam cnt_t IDX_NONE = '1;

    typedef logic [31:0] timer_t;

endpackage : aqed_pkg

// File: rtl/aqed_capture_slot.sv
// -----------------------------------------------------------------------------
// aqed_capture_slot
//   Holds one tracked sequence index (original or one duplicate). When an
//   accepted output arrives whose sequence number equals the stored index,
//   the output data is latched and the captured flag is set. The latched
//   data is compared against a reference supplied by the parent.
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   set_idx_i, idx_i  load the tracked index (one-cycle strobe)
//   out_acc_i         an output token is accepted this cycle
//   out_count_i       sequence number of that output token
//   data_out_in_i     data of that output token
//   ref_data_i        data this slot's capture is compared against
//   hit_o             this slot captures in the current cycle
//   captured_o        slot has captured its token
//   match_o           captured data equals ref_data_i
//   data_o            captured data
// -----------------------------------------------------------------------------
module aqed_capture_slot
    import aqed_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 32  // must not exceed CNT_W_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_idx_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic              out_acc_i,
    input  logic [CNT_W-1:0]  out_count_i,
    input  logic [DATA_W-1:0] data_out_in_i,
    input  logic [DATA_W-1:0] ref_data_i,
    output logic              hit_o,
    output logic              captured_o,
    output logic              match_o,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [CNT_W-1:0] IDX_SENT = IDX_NONE[CNT_W-1:0];

    logic [CNT_W-1:0]  idx_q;
    logic              captured_q;
    logic [DATA_W-1:0] data_q;

    assign hit_o = out_acc_i && !captured_q && (idx_q != IDX_SENT)
                   && (idx_q == out_count_i);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q      <= IDX_SENT;
            captured_q <= 1'b0;
        end else begin
            if (set_idx_i) begin
                idx_q <= idx_i;
            end
            if (hit_o) begin
                captured_q <= 1'b1;
            end
        end
    end

    // NOTE: the data register has no reset; captured_q qualifies it, so a
    // stale value is never observed and reset fan-out stays on control only.
    always_ff @(posedge clk) begin
        if (hit_o) begin
            data_q <= data_out_in_i;
        end
    end

    assign captured_o = captured_q;
    assign match_o    = (data_q == ref_data_i);
    assign data_o     = data_q;

endmodule : aqed_capture_slot

// File: rtl/aqed_multi_dup_checker.sv
// -----------------------------------------------------------------------------
// aqed_multi_dup_checker
//   A-QED functional-consistency checker. Tags one original write, replays
//   its data as N_DUP duplicate writes, captures the matching output tokens
//   by sequence index and reports whether all captured outputs agree.
// Ports
//   clk, reset_n   clock, synchronous active-low reset
//   clk_en         global enable; nothing changes while low
//   flush          suppresses write acceptance this cycle
//   exec_dup       marks a write as eligible for original/duplicate issue
//   wen_in/data_in stimulus write strobe and data
//   ren_in         read strobe towards the DUT
//   valid_out      DUT output valid
//   data_out_in    DUT output data
//   data_out       write data forwarded to the DUT (original data on a
//                  duplicate issue, otherwise data_in)
//   qed_done       original and all duplicate outputs captured
//   qed_check      1 while not done, else 1 iff all captured outputs equal
//   qed_fail       sticky: done with a mismatch
//   qed_timeout    sticky: TIMEOUT clk_en cycles after issue without done
// -----------------------------------------------------------------------------
module aqed_multi_dup_checker
    import aqed_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned N_DUP   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              exec_dup,
    input  logic              wen_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ren_in,
    input  logic              valid_out,
    input  logic [DATA_W-1:0] data_out_in,
    output logic [DATA_W-1:0] data_out,
    output logic              qed_done,
    output logic              qed_check,
    output logic              qed_fail,
    output logic              qed_timeout
);

    localparam int unsigned      NS       = N_DUP + 1;
    localparam int unsigned      DUP_W    = (N_DUP > 1) ? $clog2(N_DUP) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = IDX_NONE[CNT_W-1:0] - CNT_W'(1);
    localparam logic [DUP_W-1:0] DUP_LAST = DUP_W'(N_DUP - 1);

    state_e            state_q, state_d;
    logic [DUP_W-1:0]  dup_cnt_q, dup_cnt_d;
    logic [CNT_W-1:0]  in_count_q, out_count_q;
    logic [DATA_W-1:0] orig_data_q;
    timer_t            timer_q;
    logic              timer_run_q;
    logic              fail_q, timeout_q;

    logic wr_acc, out_acc, in_sat, issue_ok, orig_issue, dup_issue;
    logic all_cap, all_cap_next, all_match;
    timer_t timer_nxt;

    logic [NS-1:0]     set_idx, hit, captured, match;
    logic [DATA_W-1:0] slot_data [NS];

    assign wr_acc   = clk_en && wen_in && !flush;
    assign out_acc  = clk_en && ren_in && valid_out;
    assign in_sat   = (in_count_q == CNT_SAT);
    assign issue_ok = wr_acc && exec_dup && !in_sat;

    assign orig_issue = issue_ok && (state_q == IDLE);
    assign dup_issue  = issue_ok && (state_q == ISSUING);

    // Slot 0 tracks the original; slot k tracks duplicate k-1.
    // References form a ring (slot s compares against slot s+1), so once every
    // slot has captured, all matches set means all captured outputs are equal.
    for (genvar s = 0; s < NS; s++) begin : g_slot
        if (s == 0) begin : g_orig
            assign set_idx[s] = orig_issue;
        end else begin : g_dup
            assign set_idx[s] = dup_issue && (dup_cnt_q == DUP_W'(s - 1));
        end

        aqed_capture_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk           (clk),
            .reset_n       (reset_n),
            .set_idx_i     (set_idx[s]),
            .idx_i         (in_count_q),
            .out_acc_i     (out_acc),
            .out_count_i   (out_count_q),
            .data_out_in_i (data_out_in),
            .ref_data_i    (slot_data[(s + 1) % NS]),
            .hit_o         (hit[s]),
            .captured_o    (captured[s]),
            .match_o       (match[s]),
            .data_o        (slot_data[s])
        );
    end

    assign all_cap      = &captured;
    assign all_cap_next = &(captured | hit);
    assign all_match    = &match;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        dup_cnt_d = dup_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (orig_issue) begin
                    dup_cnt_d = '0;
                    state_d   = ISSUING;
                end
            end
            ISSUING: begin
                if (dup_issue) begin
                    dup_cnt_d = dup_cnt_q + DUP_W'(1);
                    if (dup_cnt_q == DUP_LAST) begin
                        state_d = WAIT_OUT;
                    end
                end
            end
            WAIT_OUT: begin
                if (all_cap) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timer_nxt = timer_q + timer_t'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dup_cnt_q   <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            timer_q     <= '0;
            timer_run_q <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            dup_cnt_q <= dup_cnt_d;

            if (wr_acc && !in_sat) begin
                in_count_q <= in_count_q + CNT_W'(1);
            end
            if (out_acc && (out_count_q != CNT_SAT)) begin
                out_count_q <= out_count_q + CNT_W'(1);
            end

            // Timer restarts at the original issue and then counts every
            // enabled cycle until done or timeout; a capture completing in
            // the same cycle the limit is reached wins over the timeout.
            if (orig_issue) begin
                timer_q     <= '0;
                timer_run_q <= 1'b1;
            end else if (timer_run_q && !all_cap && !timeout_q) begin
                timer_q <= timer_nxt;
                if ((TIMEOUT != 0) && (timer_nxt == timer_t'(TIMEOUT))
                    && !all_cap_next) begin
                    timeout_q <= 1'b1;
                end
            end

            if (all_cap && !all_match) begin
                fail_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && orig_issue) begin
            orig_data_q <= data_in;
        end
    end

    assign data_out    = dup_issue ? orig_data_q : data_in;
    assign qed_done    = all_cap;
    assign qed_check   = !all_cap || all_match;
    assign qed_fail    = fail_q;
    assign qed_timeout = timeout_q;

endmodule : aqed_multi_dup_checker

// File: tb/tb_aqed_multi_dup_checker.sv
// -----------------------------------------------------------------------------
// tb_aqed_multi_dup_checker
//   Directed bench for aqed_multi_dup_checker (N_DUP=2, TIMEOUT=16, CNT_W=4
//   so the input counter saturates after 14 accepted writes).
// -----------------------------------------------------------------------------
module tb_aqed_multi_dup_checker;

    localparam int unsigned DATA_W = 16;

    logic              clk;
    logic              reset_n;
    logic              clk_en;
    logic              flush;
    logic              exec_dup;
    logic              wen_in;
    logic [DATA_W-1:0] data_in;
    logic              ren_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out_in;
    logic [DATA_W-1:0] data_out;
    logic              qed_done;
    logic              qed_check;
    logic              qed_fail;
    logic              qed_timeout;

    int checks = 0;
    int errors = 0;

    aqed_multi_dup_checker #(
        .DATA_W  (DATA_W),
        .CNT_W   (4),
        .N_DUP   (2),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .flush       (flush),
        .exec_dup    (exec_dup),
        .wen_in      (wen_in),
        .data_in     (data_in),
        .ren_in      (ren_in),
        .valid_out   (valid_out),
        .data_out_in (data_out_in),
        .data_out    (data_out),
        .qed_done    (qed_done),
        .qed_check   (qed_check),
        .qed_fail    (qed_fail),
        .qed_timeout (qed_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns data_out seen mid-cycle.
    task automatic step(input logic en, input logic wen, input logic fl, input logic ex,
                        input logic [15:0] d, input logic rd, input logic [15:0] od,
                        output logic [15:0] dout);
        clk_en = en; wen_in = wen; flush = fl; exec_dup = ex; data_in = d;
        ren_in = rd; valid_out = rd; data_out_in = od;
        #1;
        dout = data_out;
        @(posedge clk);
        #1;
        clk_en = 1'b1; wen_in = 1'b0; flush = 1'b0; exec_dup = 1'b0;
        ren_in = 1'b0; valid_out = 1'b0;
    endtask

    task automatic wr(input logic ex, input logic fl, input logic [15:0] d,
                      input logic [15:0] exp_dout, input string tag);
        logic [15:0] dout;
        step(1'b1, 1'b1, fl, ex, d, 1'b0, 16'h0, dout);
        check(tag, {16'h0, dout}, {16'h0, exp_dout});
    endtask

    task automatic rd(input logic [15:0] od);
        logic [15:0] dout;
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, od, dout);
    endtask

    task automatic idle(input int n);
        logic [15:0] dout;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, dout);
    endtask

    // clk_en low with every other input busy; data_out must pass data_in.
    task automatic gap(input int n, input string tag);
        logic [15:0] dout;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b1, 16'hBEEF, dout);
            check(tag, {16'h0, dout}, 32'h0000DEAD);
        end
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        clk_en = 1'b1; wen_in = 1'b0; flush = 1'b0; exec_dup = 1'b0; data_in = '0;
        ren_in = 1'b0; valid_out = 1'b0; data_out_in = '0;
        @(posedge clk);
        #1;
        check({tag, "_rst_done"}, {31'h0, qed_done}, 32'd0);
        check({tag, "_rst_check"}, {31'h0, qed_check}, 32'd1);
        check({tag, "_rst_fail"}, {31'h0, qed_fail}, 32'd0);
        check({tag, "_rst_timeout"}, {31'h0, qed_timeout}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; clk_en = 1'b0; flush = 1'b0; exec_dup = 1'b0; wen_in = 1'b0;
        data_in = '0; ren_in = 1'b0; valid_out = 1'b0; data_out_in = '0;
        @(posedge clk);
        #1;

        // 1: in-order identity outputs, all equal
        do_reset("s1");
        wr(1'b1, 1'b0, 16'h1234, 16'h1234, "s1_w0_dout");
        wr(1'b1, 1'b0, 16'hAAAA, 16'h1234, "s1_w1_dout");
        wr(1'b1, 1'b0, 16'hBBBB, 16'h1234, "s1_w2_dout");
        wr(1'b1, 1'b0, 16'h6666, 16'h6666, "s1_w3_other_dout");
        rd(16'h1234);
        rd(16'h1234);
        check("s1_done_early", {31'h0, qed_done}, 32'd0);
        rd(16'h1234);
        check("s1_done", {31'h0, qed_done}, 32'd1);
        check("s1_check", {31'h0, qed_check}, 32'd1);
        idle(1);
        check("s1_fail", {31'h0, qed_fail}, 32'd0);

        // 2: second duplicate output corrupted
        do_reset("s2");
        wr(1'b1, 1'b0, 16'h1234, 16'h1234, "s2_w0_dout");
        wr(1'b1, 1'b0, 16'h1111, 16'h1234, "s2_w1_dout");
        wr(1'b1, 1'b0, 16'h2222, 16'h1234, "s2_w2_dout");
        rd(16'h1234);
        rd(16'h1234);
        rd(16'h1235);
        check("s2_done", {31'h0, qed_done}, 32'd1);
        check("s2_check", {31'h0, qed_check}, 32'd0);
        check("s2_fail_same_cycle", {31'h0, qed_fail}, 32'd0);
        idle(1);
        check("s2_fail_next", {31'h0, qed_fail}, 32'd1);
        idle(3);
        check("s2_fail_sticky", {31'h0, qed_fail}, 32'd1);

        // 3: plain writes before the original, one flushed exec write
        do_reset("s3");
        wr(1'b0, 1'b0, 16'h0001, 16'h0001, "s3_p0_dout");
        wr(1'b0, 1'b0, 16'h0002, 16'h0002, "s3_p1_dout");
        wr(1'b0, 1'b0, 16'h0003, 16'h0003, "s3_p2_dout");
        wr(1'b1, 1'b1, 16'h5555, 16'h5555, "s3_flush_dout");
        wr(1'b1, 1'b0, 16'h1234, 16'h1234, "s3_orig_dout");
        wr(1'b1, 1'b0, 16'h2222, 16'h1234, "s3_d0_dout");
        wr(1'b1, 1'b0, 16'h3333, 16'h1234, "s3_d1_dout");
        rd(16'h0001);
        rd(16'h0002);
        rd(16'h0003);
        rd(16'h1234);
        rd(16'h1234);
        check("s3_done_early", {31'h0, qed_done}, 32'd0);
        rd(16'h1234);
        check("s3_done", {31'h0, qed_done}, 32'd1);
        check("s3_check", {31'h0, qed_check}, 32'd1);

        // 4: no outputs ever; timeout after 16 enabled cycles
        do_reset("s4");
        wr(1'b1, 1'b0, 16'h1234, 16'h1234, "s4_w0_dout");
        idle(10);
        gap(3, "s4_gap_dout");
        idle(5);
        check("s4_timeout_at15", {31'h0, qed_timeout}, 32'd0);
        idle(1);
        check("s4_timeout_at16", {31'h0, qed_timeout}, 32'd1);
        check("s4_done", {31'h0, qed_done}, 32'd0);
        idle(3);
        check("s4_timeout_sticky", {31'h0, qed_timeout}, 32'd1);

        // 5: clk_en low mid-issue freezes everything
        do_reset("s5");
        wr(1'b1, 1'b0, 16'h1234, 16'h1234, "s5_w0_dout");
        gap(5, "s5_gap_dout");
        wr(1'b1, 1'b0, 16'hAAAA, 16'h1234, "s5_w1_dout");
        wr(1'b1, 1'b0, 16'hBBBB, 16'h1234, "s5_w2_dout");
        wr(1'b1, 1'b0, 16'h7777, 16'h7777, "s5_w3_other_dout");
        rd(16'h1234);
        rd(16'h1234);
        check("s5_done_early", {31'h0, qed_done}, 32'd0);
        rd(16'h1234);
        check("s5_done", {31'h0, qed_done}, 32'd1);
        check("s5_check", {31'h0, qed_check}, 32'd1);

        // 6: reset during WAIT_OUT, then a fresh run
        do_reset("s6a");
        wr(1'b1, 1'b0, 16'h1234, 16'h1234, "s6_w0_dout");
        wr(1'b1, 1'b0, 16'h0BAD, 16'h1234, "s6_w1_dout");
        wr(1'b1, 1'b0, 16'h0BAD, 16'h1234, "s6_w2_dout");
        rd(16'h1234);
        rd(16'h9999);
        do_reset("s6b");
        wr(1'b1, 1'b0, 16'h4321, 16'h4321, "s6_f0_dout");
        wr(1'b1, 1'b0, 16'h0000, 16'h4321, "s6_f1_dout");
        wr(1'b1, 1'b0, 16'hFFFF, 16'h4321, "s6_f2_dout");
        rd(16'h4321);
        rd(16'h4321);
        rd(16'h4321);
        check("s6_done", {31'h0, qed_done}, 32'd1);
        check("s6_check", {31'h0, qed_check}, 32'd1);
        idle(1);
        check("s6_fail", {31'h0, qed_fail}, 32'd0);

        // 7: input counter saturated (14 writes at CNT_W=4): no issue at all
        do_reset("s7");
        for (int i = 0; i < 14; i++) wr(1'b0, 1'b0, 16'(i), 16'(i), "s7_plain_dout");
        wr(1'b1, 1'b0, 16'h4444, 16'h4444, "s7_sat_w0_dout");
        wr(1'b1, 1'b0, 16'h5555, 16'h5555, "s7_sat_w1_dout");
        idle(20);
        check("s7_timeout", {31'h0, qed_timeout}, 32'd0);
        check("s7_done", {31'h0, qed_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_aqed_multi_dup_checker
